regfile_param: RTL and testbench



---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_rdport.sv | 49 ++++
 rtl/regfile_param.sv | 97 +++++++++
 tb/tb_regfile_param.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parameterised register file.
// Error flag bit positions and a constant clog2 used for address widths.
package regfile_pkg;

   localparam int ERR_RANGE = 0;
   localparam int ERR_RBW   = 1;
   localparam int ERR_W     = 2;

   // Ceiling log2, never below 1 so a 2-entry file still gets an address bit.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/regfile_rdport.sv
// Combinational read port: range check, bypass mux, valid lookup, error detect.
// Zero latency; no backpressure, result follows the address in the same cycle.
module regfile_rdport
   import regfile_pkg::*;
#(
   parameter int WIDTH = 9,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic                         en,
   input  logic [AW-1:0]                addr,
   input  logic [DEPTH-1:0][WIDTH-1:0]  mem,
   input  logic [DEPTH-1:0]             valid,
   input  logic                         byp_en,
   input  logic [AW-1:0]                byp_addr,
   input  logic [WIDTH-1:0]             byp_data,
   output logic [WIDTH-1:0]             data,
   output logic                         vld,
   output logic                         err_range,
   output logic                         err_rbw
);

   logic in_range;
   logic byp_hit;

   assign in_range = int'(addr) < DEPTH;
   assign byp_hit  = byp_en && (byp_addr == addr);

   always_comb begin
      data      = '0;
      vld       = 1'b0;
      err_range = 1'b0;
      err_rbw   = 1'b0;
      if (en) begin
         if (!in_range) begin
            err_range = 1'b1;
         end else if (byp_hit) begin
            data = byp_data;
            vld  = 1'b1;
         end else begin
            data    = mem[addr];
            vld     = valid[addr];
            // An unwritten entry still reads as its (reset) contents, but is flagged.
            err_rbw = !valid[addr];
         end
      end
   end

endmodule

// File: rtl/regfile_param.sv
// Register file, 1 write + 2 combinational read ports, valid bits and sticky errors.
// Reads have zero latency, writes land on the next edge; optional write-to-read bypass via REGFILE_PARAM_BYPASS_EN.
module regfile_param
   import regfile_pkg::*;
#(
   parameter  int WIDTH = 9,
   parameter  int DEPTH = 8,
   localparam int AW    = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             chosen,
   input  logic             w_en,
   input  logic [AW-1:0]    w_addr,
   input  logic [WIDTH-1:0] w_data,
   input  logic             r_en_a,
   input  logic             r_en_b,
   input  logic [AW-1:0]    r_addr_a,
   input  logic [AW-1:0]    r_addr_b,
   output logic [WIDTH-1:0] r_data_a,
   output logic [WIDTH-1:0] r_data_b,
   output logic             r_vld_a,
   output logic             r_vld_b,
   input  logic             err_clr,
   output logic [ERR_W-1:0] err
);

   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [DEPTH-1:0]            valid;
   logic                        w_in_range;
   logic                        wr_ok;
   logic                        byp_en;
   logic                        a_err_range, a_err_rbw;
   logic                        b_err_range, b_err_rbw;
   logic [ERR_W-1:0]            err_set;

   assign w_in_range = int'(w_addr) < DEPTH;
   assign wr_ok      = chosen && w_en && w_in_range;

`ifdef REGFILE_PARAM_BYPASS_EN
   // A write that reset is about to discard must not be forwarded either.
   assign byp_en = wr_ok && rst;
`else
   assign byp_en = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         mem   <= '0;
         valid <= '0;
      end else if (wr_ok) begin
         mem[w_addr]   <= w_data;
         valid[w_addr] <= 1'b1;
      end
   end

   regfile_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_rd_a (
      .en        (r_en_a),
      .addr      (r_addr_a),
      .mem       (mem),
      .valid     (valid),
      .byp_en    (byp_en),
      .byp_addr  (w_addr),
      .byp_data  (w_data),
      .data      (r_data_a),
      .vld       (r_vld_a),
      .err_range (a_err_range),
      .err_rbw   (a_err_rbw)
   );

   regfile_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_rd_b (
      .en        (r_en_b),
      .addr      (r_addr_b),
      .mem       (mem),
      .valid     (valid),
      .byp_en    (byp_en),
      .byp_addr  (w_addr),
      .byp_data  (w_data),
      .data      (r_data_b),
      .vld       (r_vld_b),
      .err_range (b_err_range),
      .err_rbw   (b_err_rbw)
   );

   assign err_set[ERR_RANGE] = chosen && ((w_en && !w_in_range) || a_err_range || b_err_range);
   assign err_set[ERR_RBW]   = chosen && (a_err_rbw || b_err_rbw);

   // New errors override a simultaneous clear.
   always_ff @(posedge clk) begin
      if (!rst) begin
         err <= '0;
      end else begin
         err <= (err_clr ? '0 : err) | err_set;
      end
   end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: directed scenarios plus randomized traffic against an array model.
// A second DEPTH=6 instance exercises out-of-range addressing.
module tb_regfile_param;

   localparam int W  = 9;
   localparam int D  = 8;
   localparam int D6 = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, chosen, w_en, r_en_a, r_en_b, err_clr;
   logic [2:0]    w_addr, r_addr_a, r_addr_b;
   logic [W-1:0]  w_data, r_data_a, r_data_b;
   logic          r_vld_a, r_vld_b;
   logic [1:0]    err;

   logic          s_rst, s_chosen, s_w_en, s_r_en_a, s_r_en_b, s_err_clr;
   logic [2:0]    s_w_addr, s_r_addr_a, s_r_addr_b;
   logic [W-1:0]  s_w_data, s_r_data_a, s_r_data_b;
   logic          s_r_vld_a, s_r_vld_b;
   logic [1:0]    s_err;

   regfile_param #(.WIDTH(W), .DEPTH(D)) u_dut (
      .clk(clk), .rst(rst), .chosen(chosen), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
      .r_en_a(r_en_a), .r_en_b(r_en_b), .r_addr_a(r_addr_a), .r_addr_b(r_addr_b),
      .r_data_a(r_data_a), .r_data_b(r_data_b), .r_vld_a(r_vld_a), .r_vld_b(r_vld_b),
      .err_clr(err_clr), .err(err)
   );

   regfile_param #(.WIDTH(W), .DEPTH(D6)) u_d6 (
      .clk(clk), .rst(s_rst), .chosen(s_chosen), .w_en(s_w_en), .w_addr(s_w_addr), .w_data(s_w_data),
      .r_en_a(s_r_en_a), .r_en_b(s_r_en_b), .r_addr_a(s_r_addr_a), .r_addr_b(s_r_addr_b),
      .r_data_a(s_r_data_a), .r_data_b(s_r_data_b), .r_vld_a(s_r_vld_a), .r_vld_b(s_r_vld_b),
      .err_clr(s_err_clr), .err(s_err)
   );

   logic [W-1:0] m_mem [D];
   bit           m_vld [D];
   logic [1:0]   m_err;
   int           n_tests = 0;
   int           n_fail  = 0;

   function automatic bit m_byp(int addr);
`ifdef REGFILE_PARAM_BYPASS_EN
      return rst && chosen && w_en && (int'(w_addr) < D) && (addr == int'(w_addr));
`else
      return (addr < 0);
`endif
   endfunction

   function automatic logic [W-1:0] m_rd(bit en, int addr);
      if (!en || addr >= D) return '0;
      if (m_byp(addr)) return w_data;
      return m_mem[addr];
   endfunction

   function automatic bit m_rv(bit en, int addr);
      if (!en || addr >= D) return 1'b0;
      if (m_byp(addr)) return 1'b1;
      return m_vld[addr];
   endfunction

   function automatic bit m_rbw(bit en, int addr);
      return en && addr < D && !m_vld[addr] && !m_byp(addr);
   endfunction

   // Advance one clock, applying the current inputs to the model at the edge.
   task automatic tick();
      logic [1:0] set;
      @(posedge clk);
      set = 2'b00;
      if (!rst) begin
         for (int i = 0; i < D; i++) begin
            m_mem[i] = '0;
            m_vld[i] = 1'b0;
         end
         m_err = 2'b00;
      end else begin
         if (chosen) begin
            if (w_en && int'(w_addr) >= D) set[0] = 1'b1;
            if (r_en_a && int'(r_addr_a) >= D) set[0] = 1'b1;
            if (r_en_b && int'(r_addr_b) >= D) set[0] = 1'b1;
            if (m_rbw(r_en_a, int'(r_addr_a)) || m_rbw(r_en_b, int'(r_addr_b))) set[1] = 1'b1;
         end
         m_err = (err_clr ? 2'b00 : m_err) | set;
         if (chosen && w_en && int'(w_addr) < D) begin
            m_mem[w_addr] = w_data;
            m_vld[w_addr] = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      rst = 1'b1; chosen = 1'b0; w_en = 1'b0; w_addr = '0; w_data = '0;
      r_en_a = 1'b0; r_en_b = 1'b0; r_addr_a = '0; r_addr_b = '0; err_clr = 1'b0;
   endtask

   task automatic s_idle();
      s_rst = 1'b1; s_chosen = 1'b0; s_w_en = 1'b0; s_w_addr = '0; s_w_data = '0;
      s_r_en_a = 1'b0; s_r_en_b = 1'b0; s_r_addr_a = '0; s_r_addr_b = '0; s_err_clr = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b0;
      tick();
      idle();
      r_en_a = 1'b1; r_addr_a = 3'd0; r_en_b = 1'b1; r_addr_b = 3'd7;
      #1;
      n_tests++; if (r_data_a !== 9'h000) begin n_fail++; $display("FAIL reset_data_a: got %h want 000", r_data_a); end
      n_tests++; if (r_vld_a !== 1'b0)    begin n_fail++; $display("FAIL reset_vld_a: got %b want 0", r_vld_a); end
      n_tests++; if (r_vld_b !== 1'b0)    begin n_fail++; $display("FAIL reset_vld_b: got %b want 0", r_vld_b); end
      n_tests++; if (err !== 2'b00)       begin n_fail++; $display("FAIL reset_err: got %b want 00", err); end
   endtask

   task automatic test_basic();
      idle();
      chosen = 1'b1; w_en = 1'b1; w_addr = 3'd3; w_data = 9'h1A5;
      tick();
      idle();
      chosen = 1'b1; r_en_a = 1'b1; r_addr_a = 3'd3;
      #1;
      n_tests++; if (r_data_a !== 9'h1A5) begin n_fail++; $display("FAIL basic_data: got %h want 1a5", r_data_a); end
      n_tests++; if (r_vld_a !== 1'b1)    begin n_fail++; $display("FAIL basic_vld: got %b want 1", r_vld_a); end
      tick();
      n_tests++; if (err !== 2'b00)       begin n_fail++; $display("FAIL basic_err: got %b want 00", err); end
   endtask

   task automatic test_rbw();
      idle();
      chosen = 1'b1; r_en_b = 1'b1; r_addr_b = 3'd5;
      #1;
      n_tests++; if (r_data_b !== 9'h000) begin n_fail++; $display("FAIL rbw_data: got %h want 000", r_data_b); end
      n_tests++; if (r_vld_b !== 1'b0)    begin n_fail++; $display("FAIL rbw_vld: got %b want 0", r_vld_b); end
      tick();
      idle();
      #1;
      n_tests++; if (err !== 2'b10) begin n_fail++; $display("FAIL rbw_err: got %b want 10", err); end
      err_clr = 1'b1;
      tick();
      idle();
      #1;
      n_tests++; if (err !== 2'b00) begin n_fail++; $display("FAIL rbw_clr: got %b want 00", err); end
   endtask

   task automatic test_bypass();
      logic [W-1:0] exp_same;
      idle();
      chosen = 1'b1; w_en = 1'b1; w_addr = 3'd2; w_data = 9'h055;
      tick();
      idle();
      chosen = 1'b1; w_en = 1'b1; w_addr = 3'd2; w_data = 9'h0FF; r_en_a = 1'b1; r_addr_a = 3'd2;
`ifdef REGFILE_PARAM_BYPASS_EN
      exp_same = 9'h0FF;
`else
      exp_same = 9'h055;
`endif
      #1;
      n_tests++; if (r_data_a !== exp_same) begin n_fail++; $display("FAIL bypass_same_cycle: got %h want %h", r_data_a, exp_same); end
      tick();
      idle();
      r_en_a = 1'b1; r_addr_a = 3'd2;
      #1;
      n_tests++; if (r_data_a !== 9'h0FF) begin n_fail++; $display("FAIL bypass_next_cycle: got %h want 0ff", r_data_a); end
      n_tests++; if (err !== 2'b00)       begin n_fail++; $display("FAIL bypass_err: got %b want 00", err); end
   endtask

   task automatic test_both_ports();
      idle();
      r_en_a = 1'b1; r_addr_a = 3'd3; r_en_b = 1'b1; r_addr_b = 3'd3;
      #1;
      n_tests++; if (r_data_a !== 9'h1A5 || r_vld_a !== 1'b1) begin n_fail++; $display("FAIL both_a: got %h/%b want 1a5/1", r_data_a, r_vld_a); end
      n_tests++; if (r_data_b !== 9'h1A5 || r_vld_b !== 1'b1) begin n_fail++; $display("FAIL both_b: got %h/%b want 1a5/1", r_data_b, r_vld_b); end
   endtask

   task automatic test_chosen_and_reset_mid_write();
      idle();
      w_en = 1'b1; w_addr = 3'd1; w_data = 9'h1FF;
      tick();
      idle();
      r_en_a = 1'b1; r_addr_a = 3'd1;
      #1;
      n_tests++; if (r_data_a !== 9'h000 || r_vld_a !== 1'b0) begin n_fail++; $display("FAIL unchosen_write: got %h/%b want 000/0", r_data_a, r_vld_a); end
      n_tests++; if (err !== 2'b00) begin n_fail++; $display("FAIL unchosen_err: got %b want 00", err); end
      chosen = 1'b1; w_en = 1'b1; w_addr = 3'd4; w_data = 9'h0AA; r_en_a = 1'b0;
      tick();
      idle();
      rst = 1'b0; chosen = 1'b1; w_en = 1'b1; w_addr = 3'd4; w_data = 9'h133; r_en_a = 1'b1; r_addr_a = 3'd4;
      #1;
      n_tests++; if (r_data_a !== 9'h0AA) begin n_fail++; $display("FAIL reset_cycle_pre_state: got %h want 0aa", r_data_a); end
      tick();
      idle();
      r_en_a = 1'b1; r_addr_a = 3'd4;
      #1;
      n_tests++; if (r_data_a !== 9'h000 || r_vld_a !== 1'b0) begin n_fail++; $display("FAIL reset_mid_write: got %h/%b want 000/0", r_data_a, r_vld_a); end
      n_tests++; if (err !== 2'b00) begin n_fail++; $display("FAIL reset_mid_write_err: got %b want 00", err); end
   endtask

   task automatic test_random();
      for (int it = 0; it < 400; it++) begin
         rst      = ($urandom_range(0, 39) != 0);
         chosen   = ($urandom_range(0, 3) != 0);
         w_en     = $urandom_range(0, 1);
         w_addr   = 3'($urandom_range(0, 7));
         w_data   = W'($urandom);
         r_en_a   = ($urandom_range(0, 3) != 0);
         r_en_b   = ($urandom_range(0, 3) != 0);
         r_addr_a = ($urandom_range(0, 3) == 0) ? w_addr : 3'($urandom_range(0, 7));
         r_addr_b = 3'($urandom_range(0, 7));
         err_clr  = ($urandom_range(0, 7) == 0);
         #1;
         n_tests++; if (r_data_a !== m_rd(r_en_a, int'(r_addr_a))) begin n_fail++; $display("FAIL rand_data_a it=%0d: got %h want %h", it, r_data_a, m_rd(r_en_a, int'(r_addr_a))); end
         n_tests++; if (r_vld_a !== m_rv(r_en_a, int'(r_addr_a)))  begin n_fail++; $display("FAIL rand_vld_a it=%0d: got %b want %b", it, r_vld_a, m_rv(r_en_a, int'(r_addr_a))); end
         n_tests++; if (r_data_b !== m_rd(r_en_b, int'(r_addr_b))) begin n_fail++; $display("FAIL rand_data_b it=%0d: got %h want %h", it, r_data_b, m_rd(r_en_b, int'(r_addr_b))); end
         n_tests++; if (r_vld_b !== m_rv(r_en_b, int'(r_addr_b)))  begin n_fail++; $display("FAIL rand_vld_b it=%0d: got %b want %b", it, r_vld_b, m_rv(r_en_b, int'(r_addr_b))); end
         n_tests++; if (err !== m_err) begin n_fail++; $display("FAIL rand_err it=%0d: got %b want %b", it, err, m_err); end
         tick();
      end
      idle();
   endtask

   task automatic test_depth6();
      s_idle();
      s_rst = 1'b0;
      @(posedge clk); @(negedge clk);
      s_idle();
      s_chosen = 1'b1; s_w_en = 1'b1; s_w_addr = 3'd7; s_w_data = 9'h1AB;
      @(posedge clk); @(negedge clk);
      s_idle();
      #1;
      n_tests++; if (s_err !== 2'b01) begin n_fail++; $display("FAIL d6_range_write_err: got %b want 01", s_err); end
      for (int i = 0; i < D6; i++) begin
         s_r_en_b = 1'b1; s_r_addr_b = 3'(i);
         #1;
         n_tests++; if (s_r_data_b !== 9'h000 || s_r_vld_b !== 1'b0) begin n_fail++; $display("FAIL d6_no_store addr=%0d: got %h/%b want 000/0", i, s_r_data_b, s_r_vld_b); end
      end
      s_r_en_a = 1'b1; s_r_addr_a = 3'd7;
      #1;
      n_tests++; if (s_r_data_a !== 9'h000 || s_r_vld_a !== 1'b0) begin n_fail++; $display("FAIL d6_oor_read: got %h/%b want 000/0", s_r_data_a, s_r_vld_a); end
      s_idle();
      s_chosen = 1'b1; s_w_en = 1'b1; s_w_addr = 3'd7; s_err_clr = 1'b1;
      @(posedge clk); @(negedge clk);
      s_idle();
      #1;
      n_tests++; if (s_err !== 2'b01) begin n_fail++; $display("FAIL d6_set_wins: got %b want 01", s_err); end
      s_err_clr = 1'b1;
      @(posedge clk); @(negedge clk);
      s_idle();
      #1;
      n_tests++; if (s_err !== 2'b00) begin n_fail++; $display("FAIL d6_clear: got %b want 00", s_err); end
      s_chosen = 1'b1; s_r_en_a = 1'b1; s_r_addr_a = 3'd6;
      @(posedge clk); @(negedge clk);
      s_idle();
      #1;
      n_tests++; if (s_err !== 2'b01) begin n_fail++; $display("FAIL d6_range_read_err: got %b want 01", s_err); end
      s_chosen = 1'b1; s_w_en = 1'b1; s_w_addr = 3'd5; s_w_data = 9'h0C3;
      @(posedge clk); @(negedge clk);
      s_idle();
      s_r_en_a = 1'b1; s_r_addr_a = 3'd5;
      #1;
      n_tests++; if (s_r_data_a !== 9'h0C3 || s_r_vld_a !== 1'b1) begin n_fail++; $display("FAIL d6_top_entry: got %h/%b want 0c3/1", s_r_data_a, s_r_vld_a); end
   endtask

   initial begin
      idle();
      s_idle();
      m_err = 2'b00;
      for (int i = 0; i < D; i++) begin
         m_mem[i] = '0;
         m_vld[i] = 1'b0;
      end
      test_reset();
      test_basic();
      test_rbw();
      test_bypass();
      test_both_ports();
      test_chosen_and_reset_mid_write();
      test_random();
      test_depth6();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
